// File: rtl/mult_wb_pkg.sv
// Shared types and constants for the multiplier writeback stage.
// Op encodings follow the multiplier manager; STAGES default matches its pipeline depth.
package mult_wb_pkg;

    localparam int MULT_PPL_STAGE = 3;

    typedef enum logic [1:0] {
        MULT_OP_MUL    = 2'b00,
        MULT_OP_MULH   = 2'b01,
        MULT_OP_MULHSU = 2'b10,
        MULT_OP_MULHU  = 2'b11
    } mult_op_e;

    typedef struct packed {
        logic       vld;
        mult_op_e   op;
        logic [4:0] rd;
        logic       fuse;
        logic [4:0] rd2;
    } tag_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_ent_t;

    localparam int WB_ENT_W = $bits(wb_ent_t);

    function automatic logic [31:0] sel_result(input mult_op_e op, input logic [63:0] p_ss,
                                               input logic [63:0] p_su, input logic [63:0] p_uu);
        case (op)
            MULT_OP_MUL:    return p_uu[31:0];
            MULT_OP_MULH:   return p_ss[63:32];
            MULT_OP_MULHSU: return p_su[63:32];
            default:        return p_uu[63:32];
        endcase
    endfunction

endpackage

// File: rtl/mult_wb_if.sv
// Issue, product, writeback and hazard signals between the multiplier manager,
// the writeback stage and the register-file write arbiter.
interface mult_wb_if;
    logic        iss_valid;
    logic        iss_ready;
    logic [1:0]  iss_op;
    logic [4:0]  iss_rd;
    logic        iss_fuse;
    logic [4:0]  iss_rd2;
    logic [63:0] p_ss;
    logic [63:0] p_su;
    logic [63:0] p_uu;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] busy_mask;

    modport slave (
        input  iss_valid, iss_op, iss_rd, iss_fuse, iss_rd2, p_ss, p_su, p_uu, wb_ready,
        output iss_ready, wb_valid, wb_rd, wb_data, busy_mask
    );

    modport master (
        output iss_valid, iss_op, iss_rd, iss_fuse, iss_rd2, p_ss, p_su, p_uu, wb_ready,
        input  iss_ready, wb_valid, wb_rd, wb_data, busy_mask
    );
endinterface

// File: rtl/mult_wb_fifo.sv
// Dual-push, single-pop FIFO; push1 lands behind push0. Head visible the cycle after push.
// No internal flow control: the caller must never push beyond DEPTH; pop on empty is ignored.
module mult_wb_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 37
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push0_vld,
    input  logic [WIDTH-1:0]           push0_dat,
    input  logic                       push1_vld,
    input  logic [WIDTH-1:0]           push1_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_pop;

    assign do_pop = pop && (cnt_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (push0_vld) begin
            mem_d[wr_ptr_d] = push0_dat;
            wr_ptr_d        = wr_ptr_d + AW'(1);
        end
        if (push1_vld) begin
            mem_d[wr_ptr_d] = push1_dat;
            wr_ptr_d        = wr_ptr_d + AW'(1);
        end
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        cnt_d    = cnt_q + CW'(push0_vld) + CW'(push1_vld) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; the head is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_dat = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count    = cnt_q;

endmodule

// File: rtl/mult_wb.sv
// Multiplier writeback: tag pipeline, result select, FIFO, credit-based iss_ready and busy mask.
// Latency issue->wb_valid is STAGES+1 when empty; wb_ready backpressure is absorbed by credits.
module mult_wb
    import mult_wb_pkg::*;
#(
    parameter int STAGES = MULT_PPL_STAGE,
    parameter int DEPTH  = 8
) (
    input  logic     clk,
    input  logic     rst,
    mult_wb_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    tag_t          tag_q [STAGES];
    tag_t          tag_d [STAGES];
    tag_t          last;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   busy_q, busy_d;
    logic [CW-1:0] fifo_cnt;
    wb_ent_t       head;
    wb_ent_t       push0_dat, push1_dat;
    logic          push0_vld, push1_vld;
    logic          accept, pop;
    logic [1:0]    add;

    assign accept = bus.iss_valid && bus.iss_ready;
    assign pop    = bus.wb_valid && bus.wb_ready;
    assign last   = tag_q[STAGES-1];

    // Reserve room for a possible fused pair regardless of the current issue's fuse bit.
    assign bus.iss_ready = ({1'b0, cnt_q} + (CW+1)'(2)) <= (CW+1)'(DEPTH);

    always_comb begin
        tag_d[0] = '0;
        if (accept) begin
            tag_d[0] = '{vld: 1'b1, op: mult_op_e'(bus.iss_op), rd: bus.iss_rd,
                         fuse: bus.iss_fuse, rd2: bus.iss_rd2};
        end
        for (int i = 1; i < STAGES; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_comb begin
        push0_vld = last.vld;
        push0_dat = '{rd: last.rd, data: sel_result(last.op, bus.p_ss, bus.p_su, bus.p_uu)};
        push1_vld = last.vld && last.fuse;
        push1_dat = '{rd: last.rd2, data: bus.p_uu[31:0]};
    end

    always_comb begin
        add   = accept ? (bus.iss_fuse ? 2'd2 : 2'd1) : 2'd0;
        cnt_d = cnt_q + CW'(add) - CW'(pop);
        // Clear before set so a same-cycle re-issue to the popped rd keeps the bit.
        busy_d = busy_q;
        if (pop) busy_d[bus.wb_rd] = 1'b0;
        if (accept) begin
            busy_d[bus.iss_rd] = 1'b1;
            if (bus.iss_fuse) busy_d[bus.iss_rd2] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) tag_q[i] <= '0;
            cnt_q  <= '0;
            busy_q <= '0;
        end else begin
            tag_q  <= tag_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    mult_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WB_ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push0_vld (push0_vld),
        .push0_dat (push0_dat),
        .push1_vld (push1_vld),
        .push1_dat (push1_dat),
        .pop       (pop),
        .head_dat  (head),
        .count     (fifo_cnt)
    );

    assign bus.wb_valid  = (fifo_cnt != '0);
    assign bus.wb_rd     = head.rd;
    assign bus.wb_data   = head.data;
    assign bus.busy_mask = busy_q;

endmodule

// File: doc/mult_wb.md
# mult_wb

Multiplier writeback stage, directly downstream of the pipelined multiplier manager. It tracks each issued multiply through a tag pipeline that matches the multiplier latency, selects the 32-bit result word from the correct product when that product emerges, and queues results in a dual-push FIFO. Results leave on a valid/ready port to the register-file write arbiter. The block also exports a busy mask for hazard detection and a credit-based `iss_ready`; the multiplier cannot stall, so `iss_ready` is what prevents result loss.

## Interface
Parameters:
- `STAGES`, default `` `MULT_PPL_STAGE `` (3): cycles from issue to product valid.
- `DEPTH`, default 8: FIFO entries. Must be ≥ 2 and a power of two.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `iss_valid` in 1: multiply issued this cycle. Operands are presented to the multipliers in the same cycle.
- `iss_ready` out 1: issue accepted when `iss_valid && iss_ready`.
- `iss_op` in 2: 00 MUL (low word), 01 MULH (S×S high), 10 MULHSU (S×U high), 11 MULHU (U×U high).
- `iss_rd` in 5: destination for the primary result.
- `iss_fuse` in 1: fused pair; an extra low-word result goes to `iss_rd2`. Only legal when `iss_op` != 00.
- `iss_rd2` in 5: destination for the fused low word.
- `p_ss`, `p_su`, `p_uu` in 64 each: multiplier products, valid `STAGES` cycles after issue.
- `wb_valid` out 1: result available.
- `wb_ready` in 1: arbiter accepts the result.
- `wb_rd` out 5: result destination.
- `wb_data` out 32: result word.
- `busy_mask` out 32: bit n set while a result for xn is outstanding. Bit 0 is always 0.

## Operation
- **Tag pipeline.** `STAGES` entries, each {valid, op, rd, fuse, rd2}, shifting every cycle with no stall. Stage 0 loads on an accepted issue; otherwise valid=0.
- **Capture.** When the last tag stage is valid, its result is pushed into the FIFO:
  - op 00 → `p_uu[31:0]`
  - op 01 → `p_ss[63:32]`
  - op 10 → `p_su[63:32]`
  - op 11 → `p_uu[63:32]`
  - If fuse is set, a second entry {rd2, `p_uu[31:0]`} is pushed in the same cycle, behind the primary entry.
- **FIFO.** Up to 2 pushes and 1 pop per cycle. The head drives `wb_*`. A pop occurs on `wb_valid && wb_ready`. Order is strictly issue order.
- **Credit counter** `cnt` (0..DEPTH): results in flight plus results stored.
  - Next value: `cnt + (accept ? 1+fuse : 0) - pop`.
  - `iss_ready = (cnt + 2 <= DEPTH)`. This is conservative and independent of `iss_fuse`.
  - Guarantees the FIFO never overflows. Overflow is a design error; the bench asserts on it.
- **Busy mask.**
  - Set `busy_mask[iss_rd]` (and `busy_mask[iss_rd2]` if fused) on accept.
  - Clear `busy_mask[wb_rd]` on pop.
  - Same-cycle set and clear of the same bit: set wins.
  - Writes to bit 0 are ignored. rd=0 results still flow through and are popped normally.
- **Issuer obligations** (not checked here): no issue to a busy rd; when fused, `rd != rd2`.

## Timing
- Reset values: all tag valid=0, FIFO empty, `cnt`=0, `busy_mask`=0, `wb_valid`=0, `wb_rd`=0, `wb_data`=0, `iss_ready`=1.
- Issue accepted in cycle t → capture edge at the end of cycle t+STAGES → `wb_valid` in cycle t+STAGES+1 if the FIFO was empty.
- Fused issue: the primary result appears in t+STAGES+1; the low word follows in t+STAGES+2, given `wb_ready`=1.
- Sustained throughput with `wb_ready`=1 and DEPTH=8, STAGES=3: one non-fused issue per cycle.
- `wb_rd` and `wb_data` stay stable while `wb_valid && !wb_ready`.
- Reset asserted mid-operation discards all in-flight and stored results. Products arriving after reset are ignored because their tags were cleared.

## Structure
- Shared defines (`defines.vh`): `MULT_PPL_STAGE`, `MULT_OP_MUL`/`MULH`/`MULHSU`/`MULHU` encodings.
- Sub-module `mult_wb_fifo`: parameterised dual-push, single-pop FIFO with count output. Tag pipeline, result select, credit counter and busy logic stay in the top.

## Test plan
- MULHU, A=B=0xFFFFFFFF, rd=5 at cycle 0 → `wb_valid` at cycle 4 with rd=5, data 0xFFFFFFFE. `busy_mask[5]`=1 from cycle 1 until the pop edge.
- MULH A=0xFFFFFFFE (-2), B=3, fused, rd=6, rd2=7 → rd6=0xFFFFFFFF then rd7=0xFFFFFFFA on consecutive cycles.
- MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF → 0xFFFFFFFF. MUL A=0x00010000, B=0x00010000 → 0x00000000.
- Hold `wb_ready`=0 and issue every cycle → exactly 7 accepted, then `iss_ready`=0. Release → 7 results in order, none lost, `busy_mask` returns to 0.
- Issue 3 multiplies, assert `rst` 2 cycles later → no `wb_valid` afterwards, `busy_mask`=0, `iss_ready`=1 in the first cycle after reset.
- Issue with rd=0 → result popped with `wb_rd`=0, `busy_mask` stays 0.
